op_unit: RTL
============

OP_UNIT -- requirements
Module: op_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of din, A, B, acc and sum.
REQ-002 The block SHALL have parameter CNT_INIT, default 8, giving the value loaded into counter C by t9 (4-bit, range 0..15).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 t1  input  1  microoperation: A <= din.
REQ-006 t2  input  1  microoperation: C <= C - 1.
REQ-007 t3  input  1  microoperation: B <= B + A.
REQ-008 t4  input  1  microoperation: A <= A shifted left one bit, LSB filled with 0.
REQ-009 t9  input  1  microoperation: C <= CNT_INIT and B <= 0.
REQ-010 din  input  WIDTH  operand loaded by t1.
REQ-011 x  output  1  condition flag: A[WIDTH-1].
REQ-012 y  output  1  condition flag: C == 0.
REQ-013 acc  output  WIDTH  current A.
REQ-014 sum  output  WIDTH  current B.
REQ-015 ovf  output  1  sticky: carry out of any t3 addition.
REQ-016 err  output  1  sticky: conflicting microoperations issued.
REQ-017 ops  output  8  count of cycles with any microoperation asserted.

Function
REQ-018 The block SHALL be the operational unit executing the t1/t2/t3/t4/t9 control lines of the flowchart controller and returning conditions x, y to it.
REQ-019 x and y SHALL be decoded only from registered state and SHALL NOT depend combinationally on any t input, so the controller's combinational t-from-x,y path has no loop.
REQ-020 Every microoperation SHALL take effect at the rising clk edge of the cycle it is asserted; x and y SHALL reflect the new state in the next cycle (latency 1).
REQ-021 All operands SHALL be sampled from pre-edge register values, so t3 with t1 or t4 in the same cycle adds the old A.
REQ-022 t1 together with t4 SHALL load din (t1 wins) and SHALL set err.
REQ-023 t9 together with t2 SHALL load CNT_INIT (t9 wins) and SHALL set err.
REQ-024 t9 together with t3 SHALL clear B (t9 wins) and SHALL set err, with ovf unchanged.
REQ-025 Any other combination of t inputs SHALL execute all asserted operations in parallel with no err.
REQ-026 t3 SHALL compute B + A modulo 2^WIDTH and SHALL set ovf when the carry out is 1; ovf SHALL never clear except on reset.
REQ-027 t2 with C == 0 SHALL wrap C to 15, leaving y at 0 in the next cycle.
REQ-028 t4 SHALL discard A[WIDTH-1].
REQ-029 ops SHALL increment by 1 in each cycle in which at least one t input is high, and SHALL saturate at 255.
REQ-030 With no t input asserted, all registers SHALL hold their values.

Reset
REQ-031 res high at a rising edge SHALL set A=0, B=0, C=0, ovf=0, err=0, ops=0, which gives x=0 and y=1.
REQ-032 res SHALL take priority over every t input asserted in the same cycle.
REQ-033 Outputs SHALL be undefined-free from the first edge with res high.

Verification
REQ-034 Reset: apply res for 1 cycle with t1=1 and din=0xFF -> acc=0x00, sum=0x00, x=0, y=1, ovf=0, err=0, ops=0.
REQ-035 Load and add: apply t9, then t1 with din=0x35, then t3 five times -> sum=0x35,0x6A,0x9F,0xD4,0x09; ovf rises with the fifth add; y=0 throughout; ops=7.
REQ-036 Shift: with A=0x35, apply t4 four times -> acc=0x6A/x=0, 0xD4/x=1, 0xA8/x=1, 0x50/x=0.
REQ-037 Count: apply t9 (C=8), then t2 eight times -> y=1 only after the eighth; a ninth t2 gives C=15 and y=0.
REQ-038 Conflicts: with A=0x35 and C=3, apply t1+t4 (din=0x81) in one cycle, then t2+t9 -> acc=0x81, x=1, C=8, err=1 from the first conflict cycle onward.
REQ-039 Saturation and reset mid-run: hold t2 for 300 cycles -> ops stays at 255; assert res with t3 high -> all registers zero on the next edge.

Source files
------------

// File: rtl/op_unit.sv
// op_unit: operational unit executing t1/t2/t3/t4/t9 microoperations and returning conditions x, y
module op_unit #(
    parameter int WIDTH = 8,
    parameter logic [3:0] CNT_INIT = 4'd8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             t1,
    input  logic             t2,
    input  logic             t3,
    input  logic             t4,
    input  logic             t9,
    input  logic [WIDTH-1:0] din,
    output logic             x,
    output logic             y,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             err,
    output logic [7:0]       ops
);
    logic [3:0]       c;
    logic [WIDTH:0]   s;
    logic             any_t, conflict;
    assign s        = {1'b0, sum} + {1'b0, acc};
    assign any_t    = t1 | t2 | t3 | t4 | t9;
    assign conflict = (t1 & t4) | (t9 & t2) | (t9 & t3);
    assign x        = acc[WIDTH-1];
    assign y        = c == 4'd0;
    always_ff @(posedge clk) begin
        if (res) begin
            acc <= '0;
            sum <= '0;
            c   <= '0;
            ovf <= 1'b0;
            err <= 1'b0;
            ops <= '0;
        end else begin
            if (t1) acc <= din;
            else if (t4) acc <= {acc[WIDTH-2:0], 1'b0};
            if (t9) c <= CNT_INIT;
            else if (t2) c <= c - 4'd1;
            if (t9) sum <= '0;
            else if (t3) sum <= s[WIDTH-1:0];
            if (t3 && !t9 && s[WIDTH]) ovf <= 1'b1;
            if (conflict) err <= 1'b1;
            if (any_t && ops != 8'hFF) ops <= ops + 8'd1;
        end
    end
endmodule
